// File: rtl/add_sub4.sv
// WIDTH-bit registered two's-complement adder/subtractor built from a ripple chain of full-adder cells.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output ovf.

module add_sub4_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module add_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] av,
    input  logic [WIDTH-1:0] bv,
    input  logic             M,
    output logic [WIDTH-1:0] resultv,
    output logic             cout
`ifdef ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Subtract is a + ~b + 1: invert B here and feed M in as carry-in.
    logic [WIDTH-1:0] ToBorNotToB;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign ToBorNotToB = bv ^ {WIDTH{M}};
    assign carry[0]    = M;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        add_sub4_fa u_fa (
            .a_i (av[i]),
            .b_i (ToBorNotToB[i]),
            .c_i (carry[i]),
            .s_o (sum[i]),
            .c_o (carry[i+1])
        );
    end

    logic [WIDTH-1:0] result_d, result_q;
    logic             cout_d, cout_q;

    assign result_d = sum;
    assign cout_d   = carry[WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign resultv = result_q;
    assign cout    = cout_q;

`ifdef ADDSUB_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_d, ovf_q;

    assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub4.sv
// Directed vector table, reset/in-flight sequences and an exhaustive back-to-back sweep for add_sub4.
// Build with ADDSUB_OVF_EN defined to also check ovf.

module tb_add_sub4;

    logic       clk;
    logic       reset;
    logic [3:0] av;
    logic [3:0] bv;
    logic       M;
    logic [3:0] resultv;
    logic       cout;
    logic       ovf_w;

    int checks;
    int errors;

    add_sub4 #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .av      (av),
        .bv      (bv),
        .M       (M),
        .resultv (resultv),
        .cout    (cout)
`ifdef ADDSUB_OVF_EN
        ,
        .ovf     (ovf_w)
`endif
    );

`ifndef ADDSUB_OVF_EN
    assign ovf_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [3:0] res;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[12];
    logic [5:0] exp_q[$];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] res, input logic co, input logic ov);
        check({name, ".resultv"}, {4'b0, resultv}, {4'b0, res});
        check({name, ".cout"}, {7'b0, cout}, {7'b0, co});
`ifdef ADDSUB_OVF_EN
        check({name, ".ovf"}, {7'b0, ovf_w}, {7'b0, ov});
`endif
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic m);
        av = a;
        bv = b;
        M  = m;
    endtask

    function automatic logic [5:0] model(input int a, input int b, input logic m);
        int sa, sb, r, sr;
        logic co, ov;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        if (m) begin
            r  = a - b;
            co = (a >= b);
            sr = sa - sb;
        end else begin
            r  = a + b;
            co = (r >= 16);
            sr = sa + sb;
        end
        ov = (sr > 7) || (sr < -8);
        r  = ((r % 16) + 16) % 16;
        return {r[3:0], co, ov};
    endfunction

    initial begin
        logic [5:0] e;
        checks = 0;
        errors = 0;

        vecs[0]  = '{a: 4'd11, b: 4'd15, m: 1'b0, res: 4'd10, co: 1'b1, ov: 1'b0};
        vecs[1]  = '{a: 4'd6,  b: 4'd14, m: 1'b0, res: 4'd4,  co: 1'b1, ov: 1'b0};
        vecs[2]  = '{a: 4'd8,  b: 4'd4,  m: 1'b1, res: 4'd4,  co: 1'b1, ov: 1'b1};
        vecs[3]  = '{a: 4'd14, b: 4'd14, m: 1'b1, res: 4'd0,  co: 1'b1, ov: 1'b0};
        vecs[4]  = '{a: 4'd4,  b: 4'd8,  m: 1'b1, res: 4'd12, co: 1'b0, ov: 1'b1};
        vecs[5]  = '{a: 4'd7,  b: 4'd1,  m: 1'b0, res: 4'd8,  co: 1'b0, ov: 1'b1};
        vecs[6]  = '{a: 4'd8,  b: 4'd1,  m: 1'b1, res: 4'd7,  co: 1'b1, ov: 1'b1};
        vecs[7]  = '{a: 4'd0,  b: 4'd0,  m: 1'b0, res: 4'd0,  co: 1'b0, ov: 1'b0};
        vecs[8]  = '{a: 4'd0,  b: 4'd0,  m: 1'b1, res: 4'd0,  co: 1'b1, ov: 1'b0};
        vecs[9]  = '{a: 4'd15, b: 4'd1,  m: 1'b0, res: 4'd0,  co: 1'b1, ov: 1'b0};
        vecs[10] = '{a: 4'd3,  b: 4'd4,  m: 1'b0, res: 4'd7,  co: 1'b0, ov: 1'b0};
        vecs[11] = '{a: 4'd5,  b: 4'd7,  m: 1'b1, res: 4'd14, co: 1'b0, ov: 1'b0};

        // Reset held for two clocks with a live operation on the inputs.
        reset = 1'b0;
        apply(4'd5, 4'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_out("reset", 4'd0, 1'b0, 1'b0);
        end
        reset = 1'b1;

        // Directed table, one operation per clock.
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].m);
            #1;
            check($sformatf("vec%0d.ToBorNotToB", i), {4'b0, dut.ToBorNotToB},
                  {4'b0, (vecs[i].m ? ~vecs[i].b : vecs[i].b)});
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].co, vecs[i].ov);
        end

        // Operation in flight when reset asserts is discarded.
        apply(4'd15, 4'd1, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_out("inflight_reset", 4'd0, 1'b0, 1'b0);

        // First valid output one clock after release.
        reset = 1'b1;
        apply(4'd3, 4'd4, 1'b0);
        @(posedge clk);
        #1;
        check_out("first_after_release", 4'd7, 1'b0, 1'b0);

        // Exhaustive sweep, back to back, M toggling every cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int m = 0; m < 2; m++) begin
                    apply(a[3:0], b[3:0], m[0]);
                    exp_q.push_back(model(a, b, m[0]));
                    @(posedge clk);
                    #1;
                    e = exp_q.pop_front();
                    check($sformatf("sweep a=%0d b=%0d m=%0d resultv", a, b, m),
                          {4'b0, resultv}, {4'b0, e[5:2]});
                    check($sformatf("sweep a=%0d b=%0d m=%0d cout", a, b, m),
                          {7'b0, cout}, {7'b0, e[1]});
`ifdef ADDSUB_OVF_EN
                    check($sformatf("sweep a=%0d b=%0d m=%0d ovf", a, b, m),
                          {7'b0, ovf_w}, {7'b0, e[0]});
`endif
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
